dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS in the impedance analyzer.
- For each sweep point it does four things in order: serially writes the frequency tuning word (FTW) into the DDS, pulses the DDS I/O-update strobe, waits a programmable settle time, then hands off to the measurement path and waits for it to finish.
- Sits between the PS-side configuration registers and the DDS pins, and replaces software-driven update toggling.

Parameters:
- FTW_W, 32, tuning-word width and serial payload length.
- FTW_ADDR, 8'h04, DDS register address sent in the instruction byte (write bit = 0).
- SCLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- UPD_CYC, 4, io_update high time in clk cycles (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE.
- abort  in  1  level; cancels the sweep.
- ftw_start  in  FTW_W  first tuning word.
- ftw_step  in  FTW_W  increment per point.
- n_points  in  16  number of points.
- settle_cyc  in  16  clk cycles between io_update fall and meas_start.
- meas_done  in  1  pulse from the measurement path.
- dds_csb  out  1  serial chip select, active low.
- dds_sclk  out  1  serial clock.
- dds_sdio  out  1  serial data.
- dds_io_update  out  1  DDS update strobe, active high.
- meas_start  out  1  one-cycle pulse.
- point_idx  out  16  index of the current point.
- cur_ftw  out  FTW_W  FTW of the current point.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - dds_csb=1, dds_sclk=0, dds_sdio=0, dds_io_update=0.
  - meas_start=0, done=0, busy=0, point_idx=0, cur_ftw=0.
  - FSM=IDLE.
- Configuration inputs (ftw_start, ftw_step, n_points, settle_cyc) are captured on the accepted start. Later changes to them have no effect mid-sweep.
- FSM states: IDLE, LOAD, SHIFT, UPDATE, SETTLE, MEAS_WAIT, NEXT, FINISH.
- IDLE:
  - start with n_points=0 -> FINISH.
  - start with n_points!=0 -> LOAD; cur_ftw<=ftw_start, point_idx<=0.
- LOAD:
  - Builds the 40-bit frame {FTW_ADDR, cur_ftw} (instruction byte first, MSB first).
  - csb<=0, sdio<=frame MSB.
  - Next cycle -> SHIFT.
- SHIFT:
  - Each SCLK half-period is SCLK_DIV clk cycles.
  - sclk rises mid-bit; sdio changes only while sclk is low.
  - 40 bits are sent, so SHIFT lasts 80*SCLK_DIV cycles.
  - After the last falling edge: csb<=1 -> UPDATE.
- UPDATE: io_update held high for exactly UPD_CYC cycles, starting the cycle after csb rises -> SETTLE.
- SETTLE:
  - Counts settle_cyc cycles from io_update fall.
  - meas_start pulses on cycle settle_cyc after the fall (settle_cyc=0: same cycle io_update falls) -> MEAS_WAIT.
- MEAS_WAIT:
  - Waits for meas_done.
  - meas_done in any other state is ignored.
  - meas_done coincident with meas_start is not accepted.
- NEXT:
  - If point_idx==n_points-1 -> FINISH.
  - Otherwise point_idx+=1, cur_ftw+=ftw_step (modulo 2^FTW_W, wrap is silent) -> LOAD.
- FINISH: done=1 for one cycle -> IDLE.
- busy is high in every state except IDLE, including the FINISH cycle.
- start while busy is ignored.
- abort behaviour:
  - Acts in any non-IDLE state.
  - Next cycle: csb=1, sclk=0, io_update=0, meas_start=0, FSM=IDLE. A partial frame is left uncommitted.
  - No done pulse; point_idx and cur_ftw hold their values.
  - abort and start in the same IDLE cycle: abort wins.
- rst mid-operation: all outputs return to their reset values on the next edge.
- Timing budget: points are spaced by at least 1 + 80*SCLK_DIV + UPD_CYC + settle_cyc + 2 cycles plus the meas_done latency.

Decomposition:
- Shared package dds_pkg holds:
  - the state enum;
  - FRAME_W=40;
  - the FTW_ADDR default;
  - a write-instruction function that builds the instruction byte.
- One sub-module, dds_spi_tx:
  - Inputs: load, frame[39:0]. Outputs: csb, sclk, sdio, tx_done.
  - Owns the SCLK divider and the bit counter.
  - The FSM in dds_sweep_ctrl sequences it.

Test Plan:
- Basic sweep:
  - Stimulus: ftw_start=0x1000_0000, ftw_step=0x0100_0000, n_points=3, settle_cyc=10, meas_done returned 5 cycles after each meas_start.
  - Required response: a bench SPI slave decodes three frames, each with instruction 0x04, carrying 0x10000000, 0x11000000, 0x12000000. Three io_update pulses of 4 cycles each; point_idx steps 0,1,2; exactly one done pulse.
- FTW wrap and zero settle:
  - Stimulus: ftw_start=0xFFFF_FF00, ftw_step=0x200, n_points=2, settle_cyc=0.
  - Required response: frames 0xFFFFFF00 then 0x00000100; meas_start in the same cycle io_update falls.
- Zero points:
  - Stimulus: n_points=0 with start.
  - Required response: done exactly 2 cycles after start; csb never low; busy high for 1 cycle.
- Abort mid-shift:
  - Stimulus: abort asserted 30 clk cycles into SHIFT.
  - Required response: next cycle csb=1, sclk=0; no io_update pulse; no done; busy=0.
- Spurious inputs and reconfiguration:
  - Stimulus: start pulsed during MEAS_WAIT; meas_done pulsed during SETTLE; ftw_step changed mid-sweep.
  - Required response: all three ignored; the sweep sequence is unchanged versus the basic-sweep run.
- Reset mid-sweep:
  - Stimulus: rst asserted during UPDATE.
  - Required response: io_update=0 and all other outputs at reset values on the next edge; a fresh start afterwards runs a correct sweep.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller and its serial transmitter.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE,
    SETTLE,
    MEAS_WAIT,
    NEXT,
    FINISH
  } state_t;

  localparam int FRAME_W = 40;
  localparam logic [7:0] FTW_ADDR_DEF = 8'h04;

  // Instruction byte: R/W flag in the MSB (0 = write), register address below it.
  function automatic logic [7:0] wr_instr(input logic [7:0] addr);
    return {1'b0, addr[6:0]};
  endfunction

endpackage

// File: rtl/dds_spi_tx.sv
// Serial frame transmitter for the DDS port: MSB first, data launched while sclk is low.
module dds_spi_tx
  import dds_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame,
  output logic               csb,
  output logic               sclk,
  output logic               sdio,
  output logic               tx_done
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               active;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      csb     <= 1'b1;
      sclk    <= 1'b0;
      sdio    <= 1'b0;
      tx_done <= 1'b0;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      tx_done <= 1'b0;
      if (load) begin
        csb     <= 1'b0;
        sclk    <= 1'b0;
        sdio    <= frame[FRAME_W-1];
        shreg   <= {frame[FRAME_W-2:0], 1'b0};
        bit_cnt <= CNT_W'(FRAME_W - 1);
        div_cnt <= DIV_RELOAD;
        active  <= 1'b1;
      end else if (active) begin
        if (div_cnt == '0) begin
          div_cnt <= DIV_RELOAD;
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            // Last falling edge closes the frame; otherwise present the next bit.
            if (bit_cnt == '0) begin
              csb     <= 1'b1;
              sdio    <= 1'b0;
              active  <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              sdio    <= shreg[FRAME_W-1];
              shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: per point writes the FTW, strobes io_update, settles, then hands off to measurement.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int         FTW_W    = 32,
  parameter logic [7:0] FTW_ADDR = FTW_ADDR_DEF,
  parameter int         SCLK_DIV = 4,
  parameter int         UPD_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [FTW_W-1:0] ftw_start,
  input  logic [FTW_W-1:0] ftw_step,
  input  logic [15:0]      n_points,
  input  logic [15:0]      settle_cyc,
  input  logic             meas_done,
  output logic             dds_csb,
  output logic             dds_sclk,
  output logic             dds_sdio,
  output logic             dds_io_update,
  output logic             meas_start,
  output logic [15:0]      point_idx,
  output logic [FTW_W-1:0] cur_ftw,
  output logic             busy,
  output logic             done
);

  localparam int UPD_W = (UPD_CYC > 1) ? $clog2(UPD_CYC) : 1;

  state_t             state;
  logic [FTW_W-1:0]   step_q;
  logic [15:0]        npts_q;
  logic [15:0]        settle_q;
  logic [15:0]        set_cnt;
  logic [UPD_W-1:0]   upd_cnt;
  logic               tx_load;
  logic               tx_done;
  logic [FRAME_W-1:0] frame;

  assign tx_load = (state == LOAD);
  assign frame   = {wr_instr(FTW_ADDR), cur_ftw};

  dds_spi_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load    (tx_load),
    .abort   (abort),
    .frame   (frame),
    .csb     (dds_csb),
    .sclk    (dds_sclk),
    .sdio    (dds_sdio),
    .tx_done (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dds_io_update <= 1'b0;
      meas_start    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      point_idx     <= '0;
      cur_ftw       <= '0;
      step_q        <= '0;
      npts_q        <= '0;
      settle_q      <= '0;
      set_cnt       <= '0;
      upd_cnt       <= '0;
    end else if (abort) begin
      // Also swallows a start arriving together with abort while idle.
      state         <= IDLE;
      dds_io_update <= 1'b0;
      meas_start    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      meas_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step_q   <= ftw_step;
            npts_q   <= n_points;
            settle_q <= settle_cyc;
            busy     <= 1'b1;
            if (n_points == 16'd0) begin
              state <= FINISH;
            end else begin
              state     <= LOAD;
              cur_ftw   <= ftw_start;
              point_idx <= '0;
            end
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (tx_done) begin
            state         <= UPDATE;
            dds_io_update <= 1'b1;
            upd_cnt       <= UPD_W'(UPD_CYC - 1);
          end
        end
        UPDATE: begin
          if (upd_cnt == '0) begin
            dds_io_update <= 1'b0;
            if (settle_q == 16'd0) begin
              meas_start <= 1'b1;
              state      <= MEAS_WAIT;
            end else begin
              set_cnt <= settle_q - 16'd1;
              state   <= SETTLE;
            end
          end else begin
            upd_cnt <= upd_cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (set_cnt == 16'd0) begin
            meas_start <= 1'b1;
            state      <= MEAS_WAIT;
          end else begin
            set_cnt <= set_cnt - 16'd1;
          end
        end
        MEAS_WAIT: if (meas_done && !meas_start) state <= NEXT;
        NEXT: begin
          if (point_idx == npts_q - 16'd1) begin
            state <= FINISH;
          end else begin
            point_idx <= point_idx + 16'd1;
            cur_ftw   <= cur_ftw + step_q;
            state     <= LOAD;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
